md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multiply/divide unit for the P6 five-stage MIPS pipeline.
- Executes mult, multu, div and divu over a fixed multi-cycle latency, and owns the HI/LO register pair.
- Sits alongside the ALU in the E stage. Its busy/stall outputs feed the hazard unit, which stalls any mult/div/mfhi/mflo/mthi/mtlo in D while the unit is occupied.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1)
DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  E-stage instruction is an md op this cycle; sampled at rising edge
md_op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op
A  input  32  rs operand (forwarded value)
B  input  32  rt operand (forwarded value)
busy  output  1  registered; high while an operation is in flight
md_stall  output  1  combinational: busy | (start & md_op<=3)
HI  output  32  HI register
LO  output  32  LO register

Behaviour:
- Reset (async, any time, including mid-operation):
  - busy=0, HI=0, LO=0, counter=0, state IDLE.
  - Any in-flight result is discarded.
- States:
  - IDLE: default. On a rising edge with start=1 and md_op 0..3, latch op, A and B; load counter with MULT_CYCLES (ops 0/1) or DIV_CYCLES (ops 2/3); set busy=1; go to BUSY.
  - BUSY: each edge decrements counter. At the edge where counter==1, write the computed result to HI/LO, set busy=0 and return to IDLE, all on that same edge.
- Latency:
  - Accept at edge t0 → busy high for exactly N cycles (edges t0+1 .. t0+N-1 keep it high).
  - HI/LO update and busy falls at edge t0+N, where N = MULT_CYCLES or DIV_CYCLES.
- mthi/mtlo:
  - In IDLE with start=1: HI (mthi) or LO (mtlo) takes A on that edge.
  - No busy cycle; the other register is unchanged.
- start while busy=1: ignored entirely (operands not latched, HI/LO not written). The hazard unit guarantees this case does not occur legally.
- start with md_op 6/7: no effect.
- Operands: the values used are those latched at acceptance. A/B changes during BUSY have no effect.
- mult: 64-bit two's-complement product of A×B; HI = bits 63:32, LO = bits 31:0.
- multu: same as mult, with both operands unsigned.
- div: signed division.
  - LO = quotient, truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned division; LO = quotient, HI = remainder.
- Divide by zero (B==0, div or divu):
  - Operation runs the full DIV_CYCLES with busy asserted.
  - HI and LO are left unchanged at completion.
- HI/LO outputs stay stable (old values) throughout BUSY; the only writes are the completion edge, mthi/mtlo, and reset.
- md_stall is purely combinational and has no reset dependence beyond busy.
- Results may be computed combinationally at acceptance and held in a 64-bit result register; no iterative datapath is required.

Test Plan:
- mult: A=0xFFFFFFFF, B=2, start 1 cycle → busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE, busy=0 at the same edge.
- multu: A=0xFFFFFFFF, B=2 → after 5 cycles HI=0x00000001, LO=0xFFFFFFFE. During busy, HI/LO still hold the prior values.
- div/divu:
  - div A=0xFFFFFFF9 (-7), B=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu A=7, B=2 → LO=3, HI=1.
  - div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero: preload HI=0x11, LO=0x22 via mthi/mtlo (each takes effect next edge, busy stays 0). Then div A=5, B=0 → busy 10 cycles; HI=0x11, LO=0x22 afterwards.
- Start while busy: mult 3×4 accepted, then at cycle 2 start with divu 100/7 → ignored. Result HI=0, LO=12 at cycle 5; no second busy period. md_stall=1 on the start cycle and throughout busy.
- Reset mid-op: div 100/7 accepted, reset asserted asynchronously mid-cycle at cycle 4 → busy, HI, LO drop to 0 immediately, without waiting for an edge. No later update after reset release. A new mult 6×7 afterwards → LO=42 after 5 cycles.

Source files
------------

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO ownership; fixed-latency mult/multu (MULT_CYCLES) and div/divu (DIV_CYCLES).
// Result is computed at acceptance and committed on the final busy edge; new ops are ignored while busy.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [63:0]    res_q, res_d;
    logic           wr_q, wr_d;
    logic [31:0]    hi_q, hi_d, lo_q, lo_d;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        abs_a, abs_b, uq, ur, sq, sr, q_u, r_u;
    logic [63:0]        op_res;

    always_comb begin
        prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u = {32'd0, A} * {32'd0, B};
        abs_a  = A[31] ? (~A + 32'd1) : A;
        abs_b  = B[31] ? (~B + 32'd1) : B;
        uq     = abs_a / abs_b;
        ur     = abs_a % abs_b;
        // Quotient sign follows the operand signs, remainder follows the dividend.
        sq     = (A[31] ^ B[31]) ? (~uq + 32'd1) : uq;
        sr     = A[31] ? (~ur + 32'd1) : ur;
        q_u    = A / B;
        r_u    = A % B;
        case (md_op[1:0])
            2'd0:    op_res = prod_s;
            2'd1:    op_res = prod_u;
            2'd2:    op_res = {sr, sq};
            default: op_res = {r_u, q_u};
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        wr_d    = wr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (!md_op[2]) begin
                        res_d   = op_res;
                        wr_d    = !(md_op[1] && (B == 32'd0));
                        cnt_d   = md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        state_d = S_BUSY;
                    end else if (md_op == 3'd4) begin
                        hi_d = A;
                    end else if (md_op == 3'd5) begin
                        lo_d = A;
                    end
                end
            end
            default: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    if (wr_q) begin
                        hi_d = res_q[63:32];
                        lo_d = res_q[31:0];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            wr_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            wr_q    <= wr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy     = (state_q == S_BUSY);
    assign md_stall = busy | (start & ~md_op[2]);
    assign HI       = hi_q;
    assign LO       = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed table, multi-cycle corner sequences, randomized run against a reference model.
module tb_md_unit;

    localparam int MULT = 5;
    localparam int DIV  = 10;

    logic        clk, reset, start;
    logic [2:0]  md_op;
    logic [31:0] A, B;
    logic        busy, md_stall;
    logic [31:0] HI, LO;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] cur_hi = 32'd0;
    logic [31:0] cur_lo = 32'd0;

    md_unit #(.MULT_CYCLES(MULT), .DIV_CYCLES(DIV)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .A(A), .B(B), .busy(busy), .md_stall(md_stall), .HI(HI), .LO(LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input string nm);
        int n;
        n = op[1] ? DIV : MULT;
        start = 1'b1; md_op = op; A = a; B = b;
        #1;
        chk({nm, " stall_on_start"}, 32'(md_stall), 32'd1);
        tick();
        start = 1'b0; A = $urandom; B = $urandom;
        for (int k = 0; k < n; k++) begin
            chk({nm, " busy"}, 32'(busy), 32'd1);
            chk({nm, " hi_hold"}, HI, cur_hi);
            chk({nm, " lo_hold"}, LO, cur_lo);
            tick();
        end
        chk({nm, " busy_done"}, 32'(busy), 32'd0);
        chk({nm, " hi"}, HI, eh);
        chk({nm, " lo"}, LO, el);
        cur_hi = eh;
        cur_lo = el;
    endtask

    task automatic mt(input logic hi_sel, input logic [31:0] v);
        start = 1'b1; md_op = hi_sel ? 3'd4 : 3'd5; A = v;
        #1;
        chk("mt stall", 32'(md_stall), 32'd0);
        tick();
        start = 1'b0;
        if (hi_sel) cur_hi = v; else cur_lo = v;
        chk("mt busy", 32'(busy), 32'd0);
        chk("mt hi", HI, cur_hi);
        chk("mt lo", LO, cur_lo);
    endtask

    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] q64, r64;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: ref_result = 64'(sa * sb);
            3'd1: ref_result = {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 0) return 64'd0;
                q64 = 64'(sa / sb);
                r64 = 64'(sa % sb);
                ref_result = {r64[31:0], q64[31:0]};
            end
            default: begin
                if (b == 0) return 64'd0;
                ref_result = {a % b, a / b};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       pick = 32'd0;
            1:       pick = 32'h8000_0000;
            2:       pick = 32'hFFFF_FFFF;
            3:       pick = 32'($urandom_range(0, 20));
            default: pick = $urandom;
        endcase
    endfunction

    vec_t tbl[5];

    initial begin
        int          m_cnt;
        logic [63:0] m_res;
        bit          m_wr;
        logic [31:0] m_hi, m_lo, ra, rb;
        logic [2:0]  rop;
        logic        rst_start;

        tbl[0] = '{3'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult"};
        tbl[1] = '{3'd1, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, "multu"};
        tbl[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg"};
        tbl[3] = '{3'd3, 32'd7,         32'd2, 32'd1,         32'd3,         "divu"};
        tbl[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "div_ovf"};

        reset = 1'b1; start = 1'b0; md_op = 3'd7; A = '0; B = '0;
        tick(); tick();
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset hi", HI, 32'd0);
        chk("reset lo", LO, 32'd0);
        chk("reset stall", 32'(md_stall), 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 5; i++)
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].name);

        // HI/LO preload, then divide by zero must leave both untouched.
        mt(1'b1, 32'h11);
        mt(1'b0, 32'h22);
        run_op(3'd2, 32'd5, 32'd0, 32'h11, 32'h22, "div_by_zero");

        // md_op 6/7 has no effect.
        start = 1'b1; md_op = 3'd6; A = 32'hDEAD_BEEF;
        #1 chk("nop stall", 32'(md_stall), 32'd0);
        tick();
        start = 1'b0;
        chk("nop busy", 32'(busy), 32'd0);
        chk("nop hi", HI, 32'h11);

        // Start while busy is ignored.
        start = 1'b1; md_op = 3'd0; A = 32'd3; B = 32'd4;
        tick();
        start = 1'b0;
        chk("swb busy1", 32'(busy), 32'd1);
        tick();
        start = 1'b1; md_op = 3'd3; A = 32'd100; B = 32'd7;
        #1 chk("swb stall", 32'(md_stall), 32'd1);
        tick();
        start = 1'b0;
        for (int k = 2; k < MULT; k++) begin
            chk("swb busy", 32'(busy), 32'd1);
            chk("swb stall_busy", 32'(md_stall), 32'd1);
            tick();
        end
        chk("swb done", 32'(busy), 32'd0);
        chk("swb hi", HI, 32'd0);
        chk("swb lo", LO, 32'd12);
        for (int k = 0; k < DIV + 2; k++) begin
            tick();
            chk("swb no_second_busy", 32'(busy), 32'd0);
            chk("swb lo_stable", LO, 32'd12);
        end

        // Asynchronous reset mid-operation.
        start = 1'b1; md_op = 3'd2; A = 32'd100; B = 32'd7;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        #3 reset = 1'b1;
        #1;
        chk("rst_mid busy", 32'(busy), 32'd0);
        chk("rst_mid hi", HI, 32'd0);
        chk("rst_mid lo", LO, 32'd0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < DIV + 2; k++) begin
            tick();
            chk("rst_mid no_update_busy", 32'(busy), 32'd0);
            chk("rst_mid no_update_lo", LO, 32'd0);
            chk("rst_mid no_update_hi", HI, 32'd0);
        end
        cur_hi = 32'd0; cur_lo = 32'd0;
        run_op(3'd0, 32'd6, 32'd7, 32'd0, 32'd42, "mult_after_reset");

        // Randomized traffic against the reference model, starting from a clean reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_cnt = 0; m_res = '0; m_wr = 1'b0; m_hi = '0; m_lo = '0;
        for (int i = 0; i < 600; i++) begin
            rst_start = 1'($urandom_range(0, 1));
            rop = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            start = rst_start; md_op = rop; A = ra; B = rb;
            #1;
            chk("rnd stall", 32'(md_stall), 32'((m_cnt > 0) || (rst_start && rop < 3'd4)));
            @(posedge clk);
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0 && m_wr) begin
                    m_hi = m_res[63:32];
                    m_lo = m_res[31:0];
                end
            end else if (rst_start) begin
                if (rop < 3'd4) begin
                    m_res = ref_result(rop, ra, rb);
                    m_wr  = !(rop >= 3'd2 && rb == 0);
                    m_cnt = (rop >= 3'd2) ? DIV : MULT;
                end else if (rop == 3'd4) begin
                    m_hi = ra;
                end else if (rop == 3'd5) begin
                    m_lo = ra;
                end
            end
            #1;
            chk("rnd busy", 32'(busy), 32'(m_cnt > 0));
            chk("rnd hi", HI, m_hi);
            chk("rnd lo", LO, m_lo);
        end
        start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
